// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver behind a memory-mapped byte register with a sticky Rx_flag and error flags.
// Latency: byte and Rx_flag update on the edge of the stop-bit sample (about 9.5 bit periods + 3 cycles after the line falls).
// Backpressure: none; a byte landing while Rx_flag is still set overwrites DataRx_out and raises overrun.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SerialDataIn,
  input  logic       rx_clear,
  input  logic       err_clear,
  output logic [7:0] DataRx_out,
  output logic       Rx_flag,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_C   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [7:0]      data_q, data_d;
  logic            flag_q, flag_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            load;
  logic            ferr_set;
  logic            rx_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer inputs: the FSM only ever looks at the second stage.
  always_comb begin
    sync1_d = SerialDataIn;
    sync2_d = sync1_q;
  end

  // Receive FSM next-state: mid-bit sampling driven by a single bit-period counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit must still be low half a bit later, otherwise it was a glitch.
        if (cnt_q == HALF_C) begin
          if (!rx_s) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + IDX_ONE;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        // Back to IDLE right at the stop sample so a following start bit is caught in time.
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        // Hold off while the line is in break so it cannot retrigger a frame.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host-visible register updates: a new load or error beats a same-cycle clear.
  always_comb begin
    data_d      = load ? shift_q : data_q;
    flag_d      = load ? 1'b1 : (rx_clear ? 1'b0 : flag_q);
    overrun_d   = (load && flag_q && !rx_clear) ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
    frame_err_d = ferr_set ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
    busy_d      = (state_d != IDLE);
  end

  // State and register file, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      data_q      <= '0;
      flag_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign DataRx_out = data_q;
  assign Rx_flag    = flag_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
